// File: rtl/z80_trace_pkg.sv
// Shared types, defaults and strobe classification for the Z80 bus tracer.
package z80_trace_pkg;

  localparam int DEPTH_DEF   = 16;
  localparam int STAMP_W_DEF = 16;

  typedef enum logic [2:0] {
    TYPE_OPFETCH = 3'd0,
    TYPE_MEMRD   = 3'd1,
    TYPE_MEMWR   = 3'd2,
    TYPE_IORD    = 3'd3,
    TYPE_IOWR    = 3'd4,
    TYPE_INTA    = 3'd5
  } trc_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } trc_state_e;

  typedef struct packed {
    trc_type_e              typ;
    logic [15:0]            addr;
    logic [7:0]             data;
    logic [STAMP_W_DEF-1:0] stamp;
  } trc_entry_t;

  // First matching strobe combination wins; returns 0 when none applies.
  function automatic logic classify(input logic m1_n, input logic mreq_n,
                                    input logic iorq_n, input logic rd_n,
                                    input logic wr_n, output trc_type_e t);
    t = TYPE_OPFETCH;
    classify = 1'b1;
    if (!m1_n && !iorq_n)                t = TYPE_INTA;
    else if (!m1_n && !mreq_n && !rd_n)  t = TYPE_OPFETCH;
    else if (!mreq_n && !rd_n)           t = TYPE_MEMRD;
    else if (!mreq_n && !wr_n)           t = TYPE_MEMWR;
    else if (!iorq_n && !rd_n)           t = TYPE_IORD;
    else if (!iorq_n && !wr_n)           t = TYPE_IOWR;
    else                                 classify = 1'b0;
  endfunction

  function automatic logic is_write(input trc_type_e t);
    return (t == TYPE_MEMWR) || (t == TYPE_IOWR);
  endfunction

endpackage

// File: rtl/z80_bus_tracer_fifo.sv
// First-word-fall-through trace storage with occupancy count and synchronous clear.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 43
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = pop && (r_level != {LW{1'b0}});
  assign w_do_push = push && ((r_level != LW'(DEPTH)) || w_do_pop);

  // Storage array, cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {W{1'b0}};
    end else if (w_do_push && !clr) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; simultaneous push and pop keeps the level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
    end else if (clr) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   r_level <= r_level - {{(LW-1){1'b0}}, 1'b1};
        default: r_level <= r_level;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign valid = (r_level != {LW{1'b0}});
  assign level = r_level;

endmodule

// File: rtl/z80_bus_tracer.sv
// Captures Z80 bus transactions (type, address, data, start time) into a trace FIFO.
module z80_bus_tracer
  import z80_trace_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int STAMP_W = STAMP_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   m1_n,
  input  logic                   mreq_n,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   rfsh_n,
  input  logic [15:0]            A,
  input  logic [7:0]             di,
  input  logic [7:0]             dout,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output logic [2:0]             trc_type,
  output logic [15:0]            trc_addr,
  output logic [7:0]             trc_data,
  output logic [STAMP_W-1:0]     trc_stamp,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = 3 + 16 + 8 + STAMP_W;

  trc_state_e       r_state, w_next_state;
  trc_type_e        r_type, w_start_type;
  logic             w_start_hit, w_start, w_exit, w_push;
  logic             w_pop, w_full, w_fifo_push, w_drop;
  logic [15:0]      r_addr;
  logic [7:0]       r_data, w_data_sel;
  logic [STAMP_W-1:0] r_stamp, r_tstamp;
  logic [EW-1:0]    w_wdata, w_rdata;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  assign w_exit = (mreq_n && iorq_n) || (rd_n && wr_n);

  // Strobe classification and data-lane selection (CPU-driven for writes)
  always_comb begin
    w_start_type = TYPE_OPFETCH;
    w_start_hit  = classify(m1_n, mreq_n, iorq_n, rd_n, wr_n, w_start_type);
    if (r_state == ST_ACTIVE) w_data_sel = is_write(r_type) ? dout : di;
    else                      w_data_sel = is_write(w_start_type) ? dout : di;
  end

  // Next state; the push fires on the strobe-release edge
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_push       = 1'b0;
    if (clr) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en && rfsh_n && w_start_hit) begin
            w_start      = 1'b1;
            w_next_state = ST_ACTIVE;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (w_exit) begin
            w_push       = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_ACTIVE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Transaction header at start, data lane on every edge while active
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_type   <= TYPE_OPFETCH;
      r_addr   <= 16'h0000;
      r_data   <= 8'h00;
      r_tstamp <= {STAMP_W{1'b0}};
    end else if (w_start) begin
      r_type   <= w_start_type;
      r_addr   <= A;
      r_data   <= w_data_sel;
      r_tstamp <= r_stamp;
    end else if (r_state == ST_ACTIVE) begin
      r_data   <= w_data_sel;
    end
  end

  // Free-running timestamp; clr deliberately leaves it running
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_stamp <= {STAMP_W{1'b0}};
    else if (en)   r_stamp <= r_stamp + {{(STAMP_W-1){1'b0}}, 1'b1};
  end

  assign w_pop       = trc_valid && trc_ready;
  assign w_full      = (level == LW'(DEPTH));
  assign w_fifo_push = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;

  // Sticky overflow and saturating drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else if (clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'h01;
    end
  end

  assign w_wdata = {r_type, r_addr, r_data, r_tstamp};

  trace_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .push    (w_fifo_push),
    .wdata   (w_wdata),
    .pop     (w_pop),
    .rdata   (w_rdata),
    .valid   (trc_valid),
    .level   (level)
  );

  assign trc_type  = w_rdata[EW-1 -: 3];
  assign trc_addr  = w_rdata[EW-4 -: 16];
  assign trc_data  = w_rdata[STAMP_W+7 -: 8];
  assign trc_stamp = w_rdata[STAMP_W-1:0];
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Directed plus randomized bus traffic checked against a queue-based trace model.
module tb_z80_bus_tracer;
  import z80_trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n, en, clr, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, trc_ready;
  logic [15:0] A;
  logic [7:0]  di, dout;
  logic        trc_valid, overflow;
  logic [2:0]  trc_type;
  logic [15:0] trc_addr, trc_stamp;
  logic [7:0]  trc_data, drop_cnt;
  logic [4:0]  level;

  int          total = 0;
  int          bad = 0;
  trc_entry_t  mq[$];
  logic [15:0] m_stamp;
  int          m_drop;
  bit          m_ovf;
  bit          pend_push;
  trc_entry_t  pend_e;

  always #5 clk = ~clk;

  z80_bus_tracer #(.DEPTH(DEPTH), .STAMP_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .A(A), .di(di), .dout(dout),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_type(trc_type), .trc_addr(trc_addr),
    .trc_data(trc_data), .trc_stamp(trc_stamp), .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", trc_valid, mq.size() != 0);
    chk("level", level, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    if (mq.size() != 0) begin
      chk("head_type", trc_type, mq[0].typ);
      chk("head_addr", trc_addr, mq[0].addr);
      chk("head_data", trc_data, mq[0].data);
      chk("head_stamp", trc_stamp, mq[0].stamp);
    end
  endtask

  // One clock of the model: check, then apply clear / pop / push / stamp rules at the edge.
  task automatic step();
    bit pop_m, full_m;
    check_outputs();
    @(posedge clk);
    if (clr) begin
      mq.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      pop_m  = trc_ready && (mq.size() != 0);
      full_m = (mq.size() == DEPTH);
      if (pop_m) void'(mq.pop_front());
      if (pend_push) begin
        if (!full_m || pop_m) mq.push_back(pend_e);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    pend_push = 1'b0;
    if (en) m_stamp = m_stamp + 16'd1;
    @(negedge clk);
  endtask

  task automatic idle_bus();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic drive_strobes(input trc_type_e k);
    idle_bus();
    case (k)
      TYPE_OPFETCH: begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
      TYPE_MEMRD:   begin mreq_n = 1'b0; rd_n = 1'b0; end
      TYPE_MEMWR:   begin mreq_n = 1'b0; wr_n = 1'b0; end
      TYPE_IORD:    begin iorq_n = 1'b0; rd_n = 1'b0; end
      TYPE_IOWR:    begin iorq_n = 1'b0; wr_n = 1'b0; end
      default:      idle_bus();
    endcase
  endtask

  // A complete transaction: strobes held for len edges, then released for the push edge.
  task automatic bus_cycle(input trc_type_e k, input logic [15:0] addr, input logic [7:0] data,
                           input int len, input bit en_fall, input bit pop_exit);
    bit started;
    logic [15:0] st;
    drive_strobes(k);
    A = addr;
    if (k == TYPE_MEMWR || k == TYPE_IOWR) begin dout = data; di = 8'($urandom); end
    else begin di = data; dout = 8'($urandom); end
    started = en;
    st = m_stamp;
    for (int i = 0; i < len; i++) begin
      if (en_fall && i == 1) en = 1'b0;
      step();
    end
    idle_bus();
    di = 8'($urandom); dout = 8'($urandom); A = 16'($urandom);
    pend_push = started;
    pend_e = '{typ: k, addr: addr, data: data, stamp: st};
    if (pop_exit) trc_ready = 1'b1;
    step();
    if (pop_exit) trc_ready = 1'b0;
    if (en_fall) en = 1'b1;
  endtask

  task automatic refresh_cycle();
    rfsh_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; A = 16'($urandom);
    step(); step();
    idle_bus(); rfsh_n = 1'b1;
    step();
  endtask

  task automatic drain();
    trc_ready = 1'b1;
    for (int i = 0; i < 40 && mq.size() != 0; i++) step();
    trc_ready = 1'b0;
    step();
    chk("drained_level", level, 5'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_valid", trc_valid, 1'b0);
    chk("rst_level", level, 5'd0);
    chk("rst_type", trc_type, 3'd0);
    chk("rst_addr", trc_addr, 16'h0000);
    chk("rst_data", trc_data, 8'h00);
    chk("rst_stamp", trc_stamp, 16'h0000);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop", drop_cnt, 8'h00);
    idle_bus(); rfsh_n = 1'b1; en = 1'b1; clr = 1'b0; trc_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mq.delete(); m_stamp = 16'd0; m_drop = 0; m_ovf = 1'b0; pend_push = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; en = 1'b1; clr = 1'b0; trc_ready = 1'b0; rfsh_n = 1'b1;
    A = 16'h0000; di = 8'h00; dout = 8'h00;
    idle_bus();
    m_stamp = 16'd0; m_drop = 0; m_ovf = 1'b0; pend_push = 1'b0;
    #2;
    do_reset();
    repeat (3) step();

    // CB E6 (SET 4,(HL)) with consumer always ready; refreshes must not trace
    trc_ready = 1'b1;
    bus_cycle(TYPE_OPFETCH, 16'h0000, 8'hCB, 2, 1'b0, 1'b0);
    refresh_cycle();
    bus_cycle(TYPE_OPFETCH, 16'h0001, 8'hE6, 2, 1'b0, 1'b0);
    refresh_cycle();
    bus_cycle(TYPE_MEMRD, 16'h9F9B, 8'hF6, 3, 1'b0, 1'b0);
    bus_cycle(TYPE_MEMWR, 16'h9F9B, 8'hF6, 3, 1'b0, 1'b0);
    trc_ready = 1'b0;

    // OUT (55),A with A=3C
    bus_cycle(TYPE_OPFETCH, 16'h0002, 8'hD3, 2, 1'b0, 1'b0);
    refresh_cycle();
    bus_cycle(TYPE_MEMRD, 16'h0003, 8'h55, 3, 1'b0, 1'b0);
    bus_cycle(TYPE_IOWR, 16'h3C55, 8'h3C, 4, 1'b0, 1'b0);
    drain();

    // Twenty transactions into a stalled consumer
    for (int i = 0; i < 20; i++)
      bus_cycle(trc_type_e'($urandom_range(0, 4)), 16'($urandom), 8'($urandom), 2, 1'b0, 1'b0);
    chk("ovf_level", level, 5'd16);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_drops", drop_cnt, 8'h04);

    // Full FIFO: push and pop on the same edge
    bus_cycle(TYPE_IORD, 16'hBEEF, 8'h5A, 2, 1'b0, 1'b1);
    chk("full_pp_level", level, 5'd16);
    chk("full_pp_drops", drop_cnt, 8'h04);
    drain();

    // Clear with seven entries pending and overflow still set
    for (int i = 0; i < 7; i++)
      bus_cycle(TYPE_MEMRD, 16'($urandom), 8'($urandom), 2, 1'b0, 1'b0);
    chk("pre_clr_level", level, 5'd7);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_level", level, 5'd0);
    chk("clr_overflow", overflow, 1'b0);
    chk("clr_drops", drop_cnt, 8'h00);

    // Capture disabled: no entries and frozen timestamp
    en = 1'b0;
    for (int i = 0; i < 5; i++)
      bus_cycle(TYPE_OPFETCH, 16'(16'h0100 + i), 8'($urandom), 2, 1'b0, 1'b0);
    chk("en0_level", level, 5'd0);
    en = 1'b1;
    bus_cycle(TYPE_MEMWR, 16'h4000, 8'hA5, 2, 1'b0, 1'b0);
    // en falling mid-transaction still completes it
    bus_cycle(TYPE_MEMRD, 16'h4001, 8'h3C, 3, 1'b1, 1'b0);
    drain();

    // Randomized traffic with a randomly stalling consumer
    for (int i = 0; i < 40; i++) begin
      trc_ready = 1'($urandom_range(0, 1));
      bus_cycle(trc_type_e'($urandom_range(0, 4)), 16'($urandom), 8'($urandom),
                $urandom_range(2, 4), 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) refresh_cycle();
    end
    trc_ready = 1'b0;
    drain();

    // Reset in the middle of a memory read
    drive_strobes(TYPE_MEMRD);
    A = 16'h1234; di = 8'hAA;
    step(); step();
    do_reset();
    bus_cycle(TYPE_MEMWR, 16'h5678, 8'h99, 2, 1'b0, 1'b0);
    chk("post_rst_level", level, 5'd1);
    chk("post_rst_addr", trc_addr, 16'h5678);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
